// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared constants for the simple calculator and its display
//                stage: datapath widths and one-hot state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Calculator result width and the decimal digits needed to show it
    localparam int CALC_WIDTH = 17;
    localparam int BCD_DIGITS = 6;

    // One-hot state encoding, same style as the calculator controller
    localparam logic [2:0] c_ST_IDLE  = 3'b001;
    localparam logic [2:0] c_ST_SHIFT = 3'b010;
    localparam logic [2:0] c_ST_DONE  = 3'b100;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adjust
//  Description : Double-dabble digit correction. Adds 3 to a BCD digit of 5
//                or more so the following left shift carries correctly.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust (
    input  logic [3:0] i_d,
    output logic [3:0] o_d
);

    // Pre-shift correction: digits 5..9 become 8..12
    always_comb begin
        o_d = i_d;
        if (i_d >= 4'd5) begin
            o_d = i_d + 4'd3;
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : result_bcd_converter
//  Description : Converts the calculator result to packed BCD with an
//                iterative shift-and-add-3 sequence, one bit per cycle, and
//                produces a leading-zero blanking mask for the display.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_bcd_converter
    import calc_pkg::*;
#(
    parameter int WIDTH  = CALC_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      Bin,
    input  logic                  FlagIn,
    output logic [4*DIGITS-1:0]   Bcd,
    output logic [DIGITS-1:0]     DigitEn,
    output logic                  FlagOut,
    output logic                  Busy,
    output logic                  Valid
);

    localparam int c_CNT_W = $clog2(WIDTH);
    localparam int c_BCD_W = 4 * DIGITS;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);

    logic [2:0]           r_state;
    logic [WIDTH-1:0]     r_shift;
    logic [c_BCD_W-1:0]   r_scratch;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_flag;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [DIGITS-1:0]    r_digit_en;
    logic                 r_flag_out;
    logic                 r_busy;
    logic                 r_valid;

    logic [c_BCD_W-1:0]   w_adj;
    logic [DIGITS-1:0]    w_digit_en;

    // Per-digit add-3 correction applied to the scratch before each shift
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_d (r_scratch[4*gi +: 4]),
            .o_d (w_adj[4*gi +: 4])
        );
    end

    // Digit i is lit when it or any more significant digit is nonzero;
    // the units digit is always lit so zero shows as "0"
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_en
        if (gi == 0) begin : g_lsd
            assign w_digit_en[gi] = 1'b1;
        end else begin : g_upper
            assign w_digit_en[gi] = |r_scratch[c_BCD_W-1:4*gi];
        end
    end

    // Conversion controller: capture, WIDTH shifts, then publish the result
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= c_ST_IDLE;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_flag     <= 1'b0;
            r_bcd      <= '0;
            r_digit_en <= DIGITS'(1);
            r_flag_out <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (Start) begin
                        r_shift   <= Bin;
                        r_scratch <= '0;
                        r_flag    <= FlagIn;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    // Corrected digits and remaining binary shift as one word
                    {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST_BIT) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_bcd      <= r_scratch;
                    r_digit_en <= w_digit_en;
                    r_flag_out <= r_flag;
                    r_valid    <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= c_ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign Bcd     = r_bcd;
    assign DigitEn = r_digit_en;
    assign FlagOut = r_flag_out;
    assign Busy    = r_busy;
    assign Valid   = r_valid;

endmodule
`default_nettype wire
